// File: rtl/led_panel_shifter.sv
// Double-buffered multi-lane serial shifter for daisy-chained 8-bit LED drivers.
// Optional post-latch output blanking is enabled by defining LED_OE_BLANK_EN.
module led_panel_shifter #(
  parameter int CHANNELS     = 4,
  parameter int WIDTH        = 32,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      OE,
  input  logic                      load,
  input  logic [CHANNELS*WIDTH-1:0] data,
  output logic                      ready,
  output logic                      busy,
  output logic                      sclk,
  output logic [CHANNELS-1:0]       sdo,
  output logic                      latch,
  output logic                      oe_n,
  output logic                      frame_done,
  output logic [2:0]                state_o
);

  // Handshake: a word is taken on a rising clk edge where load && ready.
  // ready is registered and stays low while a word waits in the pending buffer.

  localparam int CNT_W = $clog2(WIDTH);
  localparam int N     = CHANNELS * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHIFT_LO = 3'd1,
    S_SHIFT_HI = 3'd2,
    S_LATCH    = 3'd3
`ifdef LED_OE_BLANK_EN
    , S_BLANK  = 3'd4
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       pend_q, pend_d;
  logic               pend_v_q, pend_v_d;
  logic [N-1:0]       shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               take;

  logic               ready_q, busy_q, sclk_q, latch_q, oe_n_q, done_q;
  logic [CHANNELS-1:0] sdo_q, sdo_d;
  logic               oe_n_d;

`ifdef LED_OE_BLANK_EN
  localparam int BLK_W = $clog2(BLANK_CYCLES + 1);
  logic [BLK_W-1:0]   blank_q, blank_d;
`else
  logic               unused_blank;
  assign unused_blank = |BLANK_CYCLES;
`endif

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    take     = 1'b0;
`ifdef LED_OE_BLANK_EN
    blank_d  = blank_q;
`endif
    case (state_q)
      S_IDLE:     take = pend_v_q;
      S_SHIFT_LO: state_d = S_SHIFT_HI;
      S_SHIFT_HI: begin
        if (cnt_q == '0) begin
          state_d = S_LATCH;
        end else begin
          state_d = S_SHIFT_LO;
          cnt_d   = cnt_q - 1'b1;
          for (int c = 0; c < CHANNELS; c++) begin
            shift_d[c*WIDTH +: WIDTH] = {shift_q[c*WIDTH +: WIDTH-1], 1'b0};
          end
        end
      end
      S_LATCH: begin
`ifdef LED_OE_BLANK_EN
        state_d = S_BLANK;
        blank_d = BLK_W'(BLANK_CYCLES - 1);
`else
        state_d = S_IDLE;
        take    = pend_v_q;
`endif
      end
`ifdef LED_OE_BLANK_EN
      S_BLANK: begin
        if (blank_q == '0) begin
          state_d = S_IDLE;
          take    = pend_v_q;
        end else begin
          blank_d = blank_q - 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Leaving IDLE/LATCH/BLANK with a word waiting starts the next frame at once.
    if (take) begin
      state_d  = S_SHIFT_LO;
      shift_d  = pend_q;
      pend_v_d = 1'b0;
      cnt_d    = CNT_W'(WIDTH - 1);
    end
    if (load && ready_q) begin
      pend_d   = data;
      pend_v_d = 1'b1;
    end

    // Outputs are derived from the next state so they register alongside it.
    for (int c = 0; c < CHANNELS; c++) begin
      sdo_d[c] = ((state_d == S_SHIFT_LO) || (state_d == S_SHIFT_HI)) ?
                 shift_d[c*WIDTH + WIDTH - 1] : 1'b0;
    end
    oe_n_d = OE;
`ifdef LED_OE_BLANK_EN
    if ((state_d == S_LATCH) || (state_d == S_BLANK)) oe_n_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      sclk_q   <= 1'b0;
      sdo_q    <= '0;
      latch_q  <= 1'b0;
      done_q   <= 1'b0;
      oe_n_q   <= 1'b1;
`ifdef LED_OE_BLANK_EN
      blank_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      ready_q  <= !pend_v_d;
      busy_q   <= (state_d != S_IDLE);
      sclk_q   <= (state_d == S_SHIFT_HI);
      sdo_q    <= sdo_d;
      latch_q  <= (state_d == S_LATCH);
      done_q   <= (state_d == S_LATCH);
      oe_n_q   <= oe_n_d;
`ifdef LED_OE_BLANK_EN
      blank_q  <= blank_d;
`endif
    end
  end

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign sclk       = sclk_q;
  assign sdo        = sdo_q;
  assign latch      = latch_q;
  assign oe_n       = oe_n_q;
  assign frame_done = done_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_led_panel_shifter.sv
// Scoreboard bench for led_panel_shifter: frames pushed on load, rebuilt from
// sdo on sclk rises and compared on each latch strobe.
module tb_led_panel_shifter;

  localparam int C = 4;
  localparam int W = 32;
  localparam int N = C * W;
`ifdef LED_OE_BLANK_EN
  localparam int FRAME_GAP  = 2*W + 1 + 4;
  localparam int OE_HI_EXP  = 5;
`else
  localparam int FRAME_GAP  = 2*W + 1;
  localparam int OE_HI_EXP  = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         OE = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] data = '0;
  logic         ready, busy, sclk, latch, oe_n, frame_done;
  logic [C-1:0] sdo;
  logic [2:0]   state_o;

  led_panel_shifter #(.CHANNELS(C), .WIDTH(W), .BLANK_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .OE(OE), .load(load), .data(data),
    .ready(ready), .busy(busy), .sclk(sclk), .sdo(sdo), .latch(latch),
    .oe_n(oe_n), .frame_done(frame_done), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [N-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] acc[C];
  int           nbits = 0;
  int           latch_cnt = 0;
  int           sclk_rises = 0;
  int           oe_hi_cnt = 0;
  logic         sclk_prev = 1'b0;
  time          t_acc = 0;
  time          t_latch = 0;
  time          latch_gap = 0;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    logic [N-1:0] got;
    logic [N-1:0] e;
    if (!rst) begin
      nbits = 0;
      sclk_prev = 1'b0;
      for (int c = 0; c < C; c++) acc[c] = '0;
    end else begin
      if (sclk && !sclk_prev) begin
        for (int c = 0; c < C; c++) acc[c] = {acc[c][W-2:0], sdo[c]};
        nbits++;
        sclk_rises++;
      end
      sclk_prev = sclk;
      if (!OE && oe_n) oe_hi_cnt++;
      if (frame_done && !latch) check("frame_done_without_latch", frame_done, 0);
      if (latch) begin
        check("frame_done_with_latch", frame_done, 1);
        check("bits_per_frame", nbits, W);
        if (exp_q.size() == 0) begin
          check("unexpected_latch", latch, 0);
        end else begin
          e = exp_q.pop_front();
          for (int c = 0; c < C; c++) got[c*W +: W] = acc[c];
          check("frame_word", got, e);
        end
        latch_gap = $time - t_latch;
        t_latch   = $time;
        latch_cnt++;
        nbits = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int t = 0;
    while (!ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!ready) check("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [N-1:0] w);
    wait_ready();
    load = 1'b1;
    data = w;
    exp_q.push_back(w);
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_latch(input int n);
    int t = 0;
    while (latch_cnt < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (latch_cnt < n) check("latch_timeout", latch_cnt, n);
  endtask

  function automatic logic [N-1:0] lanes(input logic [W-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Single frame with latency, MSB, latch-cycle and blanking checks.
  task automatic single_frame(input logic [N-1:0] w, input logic [C-1:0] msb, input string tag);
    int base;
    int rises0;
    int lc;
    base = latch_cnt;
    rises0 = sclk_rises;
    oe_hi_cnt = 0;
    send(w);
    @(negedge clk);
    check({tag, "_lo_busy"}, busy, 1);
    check({tag, "_lo_sclk"}, sclk, 0);
    check({tag, "_lo_msb"}, sdo, msb);
    @(negedge clk);
    check({tag, "_hi_sclk"}, sclk, 1);
    check({tag, "_hi_msb_held"}, sdo, msb);
    wait_latch(base + 1);
    // Cycle 1 begins at the accepting edge; latch is registered on a later edge.
    lc = int'((t_latch - t_acc - 5) / 10) + 1;
    check({tag, "_latch_cycle"}, lc, 66);
    repeat (10) @(negedge clk);
    check({tag, "_sclk_rises"}, sclk_rises - rises0, W);
    check({tag, "_oe_high_cycles"}, oe_hi_cnt, OE_HI_EXP);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    int rises0;
    int t;
    logic [N-1:0] w;

    // Reset held with load asserted: nothing may be accepted.
    rst = 1'b0;
    load = 1'b1;
    data = '1;
    OE = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_sclk", sclk, 0);
    check("rst_sdo", sdo, 0);
    check("rst_latch", latch, 0);
    check("rst_oe_n", oe_n, 1);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b1;
    load = 1'b0;
    @(negedge clk);
    check("ready_after_release", ready, 1);
    repeat (5) @(negedge clk);
    check("no_accept_in_reset", busy, 0);

    single_frame(lanes(32'hB, 32'hB, 32'hB, 32'hB), 4'b0000, "b1011");
    single_frame(lanes(32'hA5A5_0001, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000), 4'b1101, "distinct");

    // Back-to-back frames; a held third load must be ignored while ready is low.
    base = latch_cnt;
    send(lanes(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hC3C3_3C3C));
    send(lanes(32'hDEAD_BEEF, 32'h0000_FFFF, 32'h8001_8001, 32'h7FFF_FFFE));
    check("ready_low_after_b", ready, 0);
    load = 1'b1;
    data = lanes(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    repeat (10) @(negedge clk);
    load = 1'b0;
    wait_latch(base + 2);
    check("b2b_latch_spacing", 64'(latch_gap), 64'(FRAME_GAP * 10));
    repeat (150) @(negedge clk);
    check("b2b_latch_count", latch_cnt - base, 2);
    check("b2b_idle", busy, 0);

    // Mid-frame reset with a word pending: both frames are dropped.
    base = latch_cnt;
    send(lanes(32'hFFFF_0000, 32'h00FF_FF00, 32'hAAAA_5555, 32'h1357_9BDF));
    send(lanes(32'h2468_ACE0, 32'hFEDC_BA98, 32'h0000_0001, 32'h8000_0001));
    t = 0;
    while (nbits < 10 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("reach_bit10", (nbits >= 10), 1);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    rises0 = sclk_rises;
    repeat (200) @(negedge clk);
    check("midrst_no_latch", latch_cnt - base, 0);
    check("midrst_no_sclk", sclk_rises - rises0, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", ready, 1);

    // OE pass-through while idle.
    OE = 1'b1;
    @(negedge clk);
    check("oe_pass_high", oe_n, 1);
    OE = 1'b0;
    @(negedge clk);
    check("oe_pass_low", oe_n, 0);

    // Random back-to-back frames.
    base = latch_cnt;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < C; c++) w[c*W +: W] = $urandom;
      send(w);
    end
    wait_latch(base + 4);
    repeat (80) @(negedge clk);
    check("rand_latch_count", latch_cnt - base, 4);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_panel_shifter.md
# led_panel_shifter

Parametrised serial driver for the LED panel's daisy-chained 8-bit shift-register PCBs. Accepts one CHANNELS×WIDTH frame word through a ready/load handshake, double-buffers it, and shifts all channels out in parallel MSB-first on a generated serial clock. After the last bit it pulses a latch strobe. It sits between the frame source (the rA..rD register set) and the panel connector, and replaces the fixed 4×32 shifting logic in the top level.

## Interface
- CHANNELS, 4, number of parallel serial data lanes (≥1)
- WIDTH, 32, bits per lane per frame (≥2); a multiple of 8 fills whole 8-bit devices
- BLANK_CYCLES, 4, cycles oe_n is forced high after latch (used only with LED_OE_BLANK_EN; ≥1)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-low
- OE  in  1  panel output enable from controller, active-low (0 = display on)
- load  in  1  frame word valid; accepted on a rising edge where load && ready
- data  in  CHANNELS*WIDTH  frame word; lane c = data[c*WIDTH +: WIDTH]
- ready  out  1  pending buffer empty; a new word can be accepted
- busy  out  1  FSM not in IDLE
- sclk  out  1  serial clock to the shift registers; data sampled by the devices on its rising edge
- sdo  out  CHANNELS  serial data, one bit per lane
- latch  out  1  storage-register strobe, one cycle high
- oe_n  out  1  output enable to panel, active-low
- frame_done  out  1  one-cycle pulse in the latch cycle

## Operation
- Storage: pending register (CHANNELS*WIDTH) plus pending_valid; shift register (CHANNELS*WIDTH); bit counter of $clog2(WIDTH) bits; blank counter.
- ready = !pending_valid (registered).
- Accept: when load && ready, data goes into pending and pending_valid is set at that edge.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH, BLANK (BLANK only with LED_OE_BLANK_EN).
- IDLE → SHIFT_LO when pending_valid. Pending moves to the shift register, pending_valid clears, and bit counter = WIDTH-1.
- SHIFT_LO → SHIFT_HI. sclk=0 and sdo[c] = current MSB of lane c.
- SHIFT_HI: sclk=1 and sdo held.
  - If bit counter = 0, go to LATCH.
  - Otherwise go to SHIFT_LO; each lane shifts left by 1 and the counter decrements.
- LATCH: latch=1, frame_done=1, sclk=0, sdo=0. Next state is BLANK if the macro is defined; otherwise next state follows the IDLE rule.
- BLANK: stay BLANK_CYCLES cycles, then leave by the same rule as IDLE.
- Back-to-back frames: if pending_valid is set when leaving LATCH/BLANK, go directly to SHIFT_LO with no IDLE cycle.
- Simultaneous load and pending→shift transfer cannot collide, because ready is 0 while pending_valid=1. ready rises the cycle after the transfer.
- Lanes are fully independent; lane c's MSB is at data[c*WIDTH+WIDTH-1].
- oe_n = OE, except it is forced to 1 in LATCH and BLANK when the macro is defined.

## Timing
- Reset values: ready=0 during reset, then 1 from the first cycle after rst deasserts. busy=0, sclk=0, sdo=0, latch=0, oe_n=1, frame_done=0.
- rst low mid-frame: state→IDLE at that edge, the pending word is discarded, and no latch pulse is produced.
- Latency: word accepted at edge k; FSM enters SHIFT_LO at edge k+1; the MSB is on sdo during cycle k+1..k+2.
- Frame length, IDLE to LATCH inclusive: 2·WIDTH+1 cycles, plus BLANK_CYCLES with the macro.
- sdo is stable for one full cycle before and after each sclk rising edge.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- LED_OE_BLANK_EN defined:
  - BLANK state is present.
  - oe_n=1 during LATCH and BLANK_CYCLES following cycles, suppressing ghosting.
  - Frame period = 2·WIDTH+1+BLANK_CYCLES.
- LED_OE_BLANK_EN undefined:
  - No BLANK state.
  - oe_n = OE registered at all times.
  - Frame period = 2·WIDTH+1.

## Test plan
- Reset: hold rst=0 for 3 cycles with load=1 → all outputs at reset values, nothing accepted. After release, ready=1 on the next cycle.
- Single frame (CHANNELS=4, WIDTH=32): each lane = 32'b1011 with OE=0.
  - Lanes 0–3 read back 32'b1011 on sclk rising edges.
  - 28 zero bits come first, then 1,0,1,1.
  - Exactly 32 sclk rises, then latch=1 and frame_done=1 for one cycle at cycle 66 after acceptance.
- Distinct lanes: lane0=32'hA5A5_0001, lane1=0, lane2=32'hFFFF_FFFF, lane3=32'h8000_0000 → per-lane sampled words match exactly. Lane3 is 1 only on the first sclk rise.
- Back-to-back frames:
  - Load word A; load word B while busy.
  - ready falls after B is accepted.
  - SHIFT_LO for B follows LATCH/BLANK of A with no idle cycle.
  - A third load is not accepted until ready returns.
- Mid-frame reset: rst=0 at bit 10 of a frame with a pending word queued → no latch pulse, busy=0, and no further sclk edges until a new load.
- Blanking: with LED_OE_BLANK_EN and BLANK_CYCLES=4, OE=0 → oe_n=1 for exactly 5 cycles starting at LATCH, otherwise 0. Without the macro, oe_n stays 0 throughout.
